// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle between requesters, the ALU and alu_arbiter.
// master = requester/ALU side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [3:0]               alu_op;
  logic [WIDTH-1:0]         alu_result;
  logic [3:0]               alu_flags;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic [3:0]               rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_flags,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NUM_REQ requesters, one op in flight.
// Defining ALU_ARB_PERF_EN adds the perf_ops/perf_err response counters.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_err
`endif
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned CntW = ID_W + 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_result_q;
  logic [3:0]       alu_op_q, rsp_flags_q;
  logic             rsp_valid_q;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [CntW-1:0]  idx_sum;
  logic [3:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;

  // Search upward from rr_q with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    winner  = rr_q;
    idx_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_sum = {1'b0, rr_q} + CntW'(i);
      if (idx_sum >= CntW'(NUM_REQ)) idx_sum = idx_sum - CntW'(NUM_REQ);
      if (!found && bus.req_valid[idx_sum[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_op = bus.req_op[4*winner +: 4];
    win_a  = bus.req_a[WIDTH*winner +: WIDTH];
    win_b  = bus.req_b[WIDTH*winner +: WIDTH];
  end

  // Grant is combinational so a requester is accepted in the same cycle it is chosen.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == StIdle && found) bus.req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      rsp_id_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            alu_op_q <= win_op;
            alu_a_q  <= win_a;
            alu_b_q  <= win_b;
            rsp_id_q <= winner;
            rr_q     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= bus.alu_result;
          rsp_flags_q  <= bus.alu_flags;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_err_q <= '0;
    end else if (state_q == StResp && bus.rsp_ready) begin
      perf_ops_q <= perf_ops_q + 32'd1;
      if (rsp_flags_q[3]) perf_err_q <= perf_err_q + 32'd1;
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_err = perf_err_q;
`endif
endmodule
